// File: rtl/uart_tx.sv
// uart_tx: UART serializer paced by a 16x oversampling tick.
// Sends an LSB-first frame: start bit, DBIT data bits, and a stop bit of SB_TICK ticks.
module uart_tx #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            s_tick,
    input  logic            tx_start,
    input  logic [DBIT-1:0] din,
    output logic            tx,
    output logic            tx_busy,
    output logic            tx_done_tick
);

    localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;
    // Four bits cover start and data; widened only when the stop bit exceeds 16 ticks.
    localparam int SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;

    localparam logic [SW-1:0] S_LAST = SW'(15);
    localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_e;

    state_e          state_q, state_d;
    logic [SW-1:0]   s_q, s_d;
    logic [NW-1:0]   n_q, n_d;
    logic [DBIT-1:0] b_q, b_d;
    logic            tx_q, tx_d;
    logic            done_q, done_d;

    // State, counters, shift register and registered line outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic; all counters advance only on s_tick outside IDLE.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (tx_start) begin
                    state_d = START;
                    s_d     = '0;
                    b_d     = din;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s_q == S_LAST) begin
                        state_d = DATA;
                        s_d     = '0;
                        n_d     = '0;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s_q == S_LAST) begin
                        s_d = '0;
                        b_d = b_q >> 1;
                        if (n_q == N_LAST) begin
                            state_d = STOP;
                        end else begin
                            n_d = n_q + 1'b1;
                        end
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (s_q == S_STOP) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Line level follows the next state so tx changes on the same edge as the FSM.
    always_comb begin
        tx_d = 1'b1;
        unique case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = b_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    assign tx           = tx_q;
    assign tx_busy      = (state_q != IDLE);
    assign tx_done_tick = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed frames checked against a behavioural line receiver.
// A second instance covers a two-stop-bit configuration.
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       reset;
    logic       s_tick;
    logic       start1;
    logic       start2;
    logic [7:0] din;
    logic       tx1, busy1, done1;
    logic       tx2, busy2, done2;
    int         n_vec = 0;
    int         n_err = 0;
    int         lowc;

    always #5 clk = ~clk;

    uart_tx #(.DBIT(8), .SB_TICK(16)) dut (
        .clk(clk), .reset(reset), .s_tick(s_tick),
        .tx_start(start1), .din(din),
        .tx(tx1), .tx_busy(busy1), .tx_done_tick(done1)
    );

    uart_tx #(.DBIT(8), .SB_TICK(32)) dut32 (
        .clk(clk), .reset(reset), .s_tick(s_tick),
        .tx_start(start2), .din(din),
        .tx(tx2), .tx_busy(busy2), .tx_done_tick(done2)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Ideal line level after t ticks have been consumed.
    function automatic logic exp_tx(input int t, input logic [7:0] d);
        if (t < 16) return 1'b0;
        if (t < 144) return d[(t - 16) / 16];
        return 1'b1;
    endfunction

    // Caller presents tx_start at a negedge; the next posedge is acceptance (c=0).
    task automatic frame(input bit sel, input logic [7:0] d, input int sb,
                         input int dv, input bit keep, input int inj,
                         output int low);
        int         t = 0;
        int         werr = 0;
        int         tdone = -1;
        int         bdone = 1;
        logic [7:0] rx = '0;
        bit         tk = 1'b0;
        logic       o_tx, o_busy, o_done;
        low = 0;
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk);
            if (tk) t++;
            @(negedge clk);
            o_tx   = sel ? tx2 : tx1;
            o_busy = sel ? busy2 : busy1;
            o_done = sel ? done2 : done1;
            if (o_tx !== exp_tx(t, d)) werr++;
            if (o_tx === 1'b0) low++;
            if (tk && t >= 24 && t <= 136 && (t - 24) % 16 == 0)
                rx[(t - 24) / 16] = o_tx;
            if (o_done === 1'b1) begin
                tdone = t;
                bdone = (o_busy === 1'b0) ? 0 : 1;
                break;
            end
            if (o_busy !== 1'b1) werr++;
            if (c == 0 && !keep) begin
                start1 = 1'b0;
                start2 = 1'b0;
            end
            if (c == inj) begin
                start1 = 1'b1;
                din    = 8'hFF;
            end
            if (inj >= 0 && c == inj + 1) start1 = 1'b0;
            tk     = ((c + 1) % dv) == 0;
            s_tick = tk;
        end
        chk("wave", werr, 0);
        chk("done_at_tick", tdone, 144 + sb);
        chk("busy_at_done", bdone, 0);
        chk("rx_byte", 32'(rx), 32'(d));
    endtask

    task automatic idle_chk(input bit sel, input int ncyc, input string tag);
        int bad = 0;
        s_tick = 1'b1;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            if (sel) begin
                if (done2 !== 1'b0 || tx2 !== 1'b1 || busy2 !== 1'b0) bad++;
            end else begin
                if (done1 !== 1'b0 || tx1 !== 1'b1 || busy1 !== 1'b0) bad++;
            end
        end
        chk(tag, bad, 0);
    endtask

    initial begin
        reset  = 1'b1;
        s_tick = 1'b0;
        start1 = 1'b0;
        start2 = 1'b0;
        din    = '0;
        #1;
        chk("rst_tx", 32'(tx1), 1);
        chk("rst_busy", 32'(busy1), 0);
        chk("rst_done", 32'(done1), 0);
        repeat (3) @(negedge clk);
        chk("rst_tx_clocked", 32'(tx1), 1);
        reset = 1'b0;
        @(negedge clk);

        din = 8'hA5; start1 = 1'b1; s_tick = 1'b1;
        frame(1'b0, 8'hA5, 16, 1, 1'b0, -1, lowc);
        idle_chk(1'b0, 40, "idle_after_a5");

        din = 8'h00; start1 = 1'b1; s_tick = 1'b0;
        frame(1'b0, 8'h00, 16, 10, 1'b0, -1, lowc);
        chk("low_clks_div10", lowc, 1440);
        idle_chk(1'b0, 40, "idle_after_div10");

        din = 8'h3C; start1 = 1'b1; s_tick = 1'b1;
        frame(1'b0, 8'h3C, 16, 1, 1'b0, 50, lowc);
        idle_chk(1'b0, 200, "no_second_frame");

        din = 8'h01; start1 = 1'b1; s_tick = 1'b1;
        frame(1'b0, 8'h01, 16, 1, 1'b1, -1, lowc);
        din = 8'h80;
        frame(1'b0, 8'h80, 16, 1, 1'b0, -1, lowc);
        idle_chk(1'b0, 40, "idle_after_b2b");

        din = 8'hC3; start2 = 1'b1; s_tick = 1'b1;
        frame(1'b1, 8'hC3, 32, 1, 1'b0, -1, lowc);
        idle_chk(1'b1, 40, "idle_after_sb32");

        din = 8'h00; start1 = 1'b1; s_tick = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start1 = 1'b0;
        repeat (60) @(negedge clk);
        chk("pre_reset_tx", 32'(tx1), 0);
        chk("pre_reset_busy", 32'(busy1), 1);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_tx", 32'(tx1), 1);
        chk("async_rst_busy", 32'(busy1), 0);
        chk("async_rst_done", 32'(done1), 0);
        @(negedge clk);
        chk("held_rst_tx", 32'(tx1), 1);
        reset = 1'b0;
        @(negedge clk);
        din = 8'h5A; start1 = 1'b1; s_tick = 1'b1;
        frame(1'b0, 8'h5A, 16, 1, 1'b0, -1, lowc);
        idle_chk(1'b0, 20, "idle_after_reset_frame");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter DBIT, default 8, number of data bits per frame.
REQ-002 Parameter SB_TICK, default 16, number of s_tick pulses in the stop bit (16 = 1 stop bit, 24 = 1.5, 32 = 2).
REQ-003 Port clk  input  1  system clock; all state changes on its rising edge.
REQ-004 Port reset  input  1  reset; asynchronous and active-high.
REQ-005 Port s_tick  input  1  oversampling enable from the baud-rate mod-M counter: one-cycle pulse, 16 pulses per bit period.
REQ-006 Port tx_start  input  1  request to transmit din; sampled only in IDLE.
REQ-007 Port din  input  DBIT  data word; captured on the clk edge that accepts tx_start.
REQ-008 Port tx  output  1  serial line, registered, idle-high.
REQ-009 Port tx_busy  output  1  high whenever state is not IDLE.
REQ-010 Port tx_done_tick  output  1  one-clk pulse marking the end of the stop bit.

Function
REQ-011 FSM states SHALL be IDLE, START, DATA and STOP, with a 4-bit tick counter s, a bit counter n of width ceil(log2(DBIT)), and a DBIT-bit shift register b.
REQ-012 In IDLE with tx_start=1, the next edge SHALL enter START, clear s to 0, and load b with din; s_tick SHALL be ignored in IDLE.
REQ-013 In START, on each s_tick, s SHALL increment; on an s_tick with s=15 the FSM SHALL enter DATA and clear s and n.
REQ-014 In DATA, on an s_tick with s=15, s SHALL clear and b SHALL shift right by one (LSB first); if n=DBIT-1 the FSM SHALL enter STOP, otherwise n SHALL increment.
REQ-015 In STOP, on an s_tick with s=SB_TICK-1, the FSM SHALL enter IDLE and tx_done_tick SHALL be 1 for exactly that one clk cycle.
REQ-016 tx SHALL be registered and updated on the same edge as the state change: 1 in IDLE and STOP, 0 in START, b[0] in DATA; tx SHALL be glitch-free.
REQ-017 The first start-bit level (tx=0) SHALL appear on the edge that accepts tx_start (latency 1 clk).
REQ-018 Between s_tick pulses, s, n, b, state and tx SHALL hold.
REQ-019 tx_start while tx_busy=1 SHALL be ignored and SHALL NOT be queued; changes to din after acceptance SHALL NOT affect the frame.
REQ-020 Frame length SHALL be exactly 16 + 16*DBIT + SB_TICK s_tick pulses, counted from the first s_tick after acceptance.
REQ-021 tx_start held high continuously SHALL start a new frame on the cycle after tx_done_tick, which gives back-to-back frames with no idle gap.
REQ-022 s_tick asserted on every clk cycle SHALL be supported.

Reset
REQ-023 While reset=1: state=IDLE, s=0, n=0, b=0, tx=1, tx_busy=0, tx_done_tick=0, independent of clk.
REQ-024 Reset asserted mid-frame SHALL abort the frame immediately; tx SHALL return to 1 with no partial stop bit; after reset deasserts, the block SHALL accept a new tx_start.

Verification
REQ-025 Reset: assert reset mid-DATA -> tx=1 and tx_busy=0 within the same cycle, before any clk edge.
REQ-026 Single frame: DBIT=8, SB_TICK=16, s_tick every clk, din=8'hA5 -> tx=0 for 16 clks, then bits 1,0,1,0,0,1,0,1 at 16 clks each, then 1 for 16 clks; tx_done_tick on clk 160 after acceptance.
REQ-027 Real divider: s_tick from a mod-10 counter (1 pulse per 10 clks), din=8'h00 -> tx low for 9*160=1440 clks, tx_done_tick at the 160th s_tick.
REQ-028 Busy rejection: pulse tx_start with din=8'hFF during DATA of a frame carrying 8'h3C -> only 8'h3C is transmitted; no second frame and a single tx_done_tick.
REQ-029 Back-to-back: tx_start held high with din=8'h01 then 8'h80 -> the second start bit begins the clk after the first tx_done_tick; both words decode correctly.
REQ-030 Stop length: SB_TICK=32 -> stop bit lasts 32 s_ticks; tx_busy deasserts on the same edge that tx_done_tick asserts.
